// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Computes {cout, sum} = a + b + cin over WIDTH clock cycles, LSB first, by
// steering one shared single-bit full_adder cell. The requester uses a
// start/busy/done handshake; start is only looked at while idle.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   busy   - high while the serial addition is in progress
//   done   - one-cycle completion pulse
//   sum    - registered WIDTH-bit result
//   cout   - registered carry-out

// Single-bit full adder cell shared by the serial datapath.
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result bits enter at the MSB so bit 0 lands at res_sh[0] after WIDTH shifts.
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Final bit: publish directly rather than waiting one more cycle for res_sh.
          sum_d   = {fa_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: a WIDTH=8 instance for directed/random
// operations and a WIDTH=2 instance for an exhaustive back-to-back sweep.
// Expected results come from plain integer addition pushed into queues at
// issue time; monitors pop and compare on every done pulse.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  // WIDTH=8 instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  // WIDTH=2 instance
  logic       start2;
  logic [1:0] a2, b2;
  logic       cin2;
  logic       busy2, done2;
  logic [1:0] sum2;
  logic       cout2;

  int checks;
  int errors;
  int cycle;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int   dones8, dones2;
  int   issued8;
  logic [8:0] last8;
  bit   sweep_on;
  int   last_done2_cycle;
  logic done8_prev, done2_prev;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      dones8++;
      check("done8_single_cycle", {31'b0, done8_prev}, 32'd0);
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("result8", {23'b0, cout8, sum8}, {23'b0, e});
      end
    end
    done8_prev = done8;
  end

  // Monitor for the WIDTH=2 instance.
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      dones2++;
      check("done2_single_cycle", {31'b0, done2_prev}, 32'd0);
      if (sweep_on && last_done2_cycle >= 0)
        check("done2_spacing", cycle - last_done2_cycle, 32'd4);
      last_done2_cycle = cycle;
      if (q2.size() == 0) begin
        check("done2_unexpected", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = q2.pop_front();
        check("result2", {29'b0, cout2, sum2}, {29'b0, e});
      end
    end
    done2_prev = done2;
  end

  // One WIDTH=8 operation with a single-cycle start. With noise set, start is
  // re-asserted with different operands in the middle of RUN and must be ignored.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit noise);
    logic [8:0] e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e = {1'b0, a} + {1'b0, b} + {8'b0, c};
    q8.push_back(e);
    issued8++;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy8_run", {31'b0, busy8}, 32'd1);
      check("sum8_hold", {23'b0, cout8, sum8}, {23'b0, last8});
      if (noise && i >= 2 && i <= 4) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    check("busy8_after_run", {31'b0, busy8}, 32'd0);
    check("done8_at_latency", {31'b0, done8}, 32'd1);
    last8 = e;
    @(negedge clk);
    check("done8_falls", {31'b0, done8}, 32'd0);
  endtask

  initial begin
    logic [8:0] e;
    checks = 0; errors = 0; cycle = 0;
    dones8 = 0; dones2 = 0; issued8 = 0;
    last8 = '0; sweep_on = 1'b0; last_done2_cycle = -1;
    done8_prev = 1'b0; done2_prev = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_res8", {23'b0, cout8, sum8}, 32'd0);
    check("rst_busy2", {31'b0, busy2}, 32'd0);
    check("rst_res2", {29'b0, cout2, sum2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op8(8'h00, 8'h00, 1'b0, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op8(8'h3C, 8'h42, 1'b1, 1'b0);
    run_op8(8'h12, 8'h34, 1'b0, 1'b1);

    // Reset after the 4th RUN edge discards the operation with no done.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy8_before_rst", {31'b0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy8", {31'b0, busy8}, 32'd0);
    check("rst_mid_done8", {31'b0, done8}, 32'd0);
    check("rst_mid_res8", {23'b0, cout8, sum8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last8 = '0;
    repeat (12) @(negedge clk);
    check("rst_no_done_busy8", {31'b0, busy8}, 32'd0);

    run_op8(8'h01, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    // WIDTH=2 exhaustive sweep with start held high: acceptance every 4 edges.
    @(negedge clk);
    sweep_on = 1'b1;
    start2 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [4:0] kv;
      kv = 5'(k);
      a2 = kv[1:0]; b2 = kv[3:2]; cin2 = kv[4];
      e = {7'b0, a2} + {7'b0, b2} + {8'b0, cin2};
      q2.push_back(e[2:0]);
      repeat (4) @(negedge clk);
    end
    start2 = 1'b0;
    repeat (8) @(negedge clk);

    check("q8_drained", q8.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    check("dones8_count", dones8, issued8);
    check("dones2_count", dones2, 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got cycle %0d", cycle);
    $fatal(1, "timeout");
  end

endmodule
